// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial bit-pattern detector.
//
// A pattern of 1..MAX_LEN bits is compared against the most recent accepted
// serial bits. Pattern, length and overlap mode are latched by a one-cycle
// cfg_load strobe. Reset defaults give an overlapping "1001" detector.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   cfg_load     strobe: latch cfg_pattern/cfg_len/cfg_overlap, clear history
//   cfg_pattern  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last
//   cfg_len      pattern length, valid range 1..MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   in_valid     qualifies in_bit
//   in_bit       serial data bit
//   cnt_clr      clears the match counter
//   det          registered one-cycle match pulse
//   det_count    saturating match counter
//   cfg_err      high while the active configuration is invalid
module seq_detect_prog #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          LEN_W       = 4,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = 8'b0000_1001,
  parameter int unsigned          RST_LEN     = 4,
  parameter bit                   RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cnt_clr,
  output logic               det,
  output logic [CNT_W-1:0]   det_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               accept;
  logic [MAX_LEN-1:0] hist_new;
  logic [MAX_LEN-1:0] len_mask;
  logic               enough_bits;
  logic               bits_equal;
  logic               match;
  logic               cfg_len_ok;

  // A beat coinciding with a load is dropped.
  assign accept   = in_valid & ~cfg_load;
  assign hist_new = {hist_q[MAX_LEN-2:0], in_bit};

  // Only the low len_q bits take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
  end

  // fill_q counts bits before this beat, so the beat itself adds one.
  assign enough_bits = (32'(fill_q) + 32'd1) >= 32'(len_q);
  assign bits_equal  = ((hist_new ^ pattern_q) & len_mask) == '0;
  assign match       = accept & ~err_q & enough_bits & bits_equal;
  assign cfg_len_ok  = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    det_d     = match;

    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      if (cfg_len_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        err_d     = 1'b0;
      end else begin
        // Previous pattern/len stay in place but matching is blocked.
        err_d = 1'b1;
      end
    end else if (accept) begin
      hist_d = hist_new;
      if (match && !overlap_q) begin
        // Non-overlap: the next match must be built from fresh bits.
        fill_d = '0;
      end else if (32'(fill_q) < MAX_LEN) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    if (cnt_clr) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      overlap_q <= RST_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign det       = det_q;
  assign det_count = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Runtime-programmable serial bit-pattern detector; the parametrised successor of the fixed 4-bit "1001" FSM detector.
- Pattern length is selectable at runtime (1..MAX_LEN), pattern value is loadable, and overlapping vs non-overlapping detection is selectable.
- Adds an input-valid qualifier, a registered detect pulse and a saturating match counter.
- Sits between a serial bit source and control/status logic; reset defaults reproduce an overlapping "1001" detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN (ceil(log2(MAX_LEN+1))).
- CNT_W, 8, width of the match counter.
- RST_PATTERN, 8'b0000_1001, pattern loaded at reset (MAX_LEN bits).
- RST_LEN, 4, pattern length loaded at reset.
- RST_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_load  input  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
- in_valid  input  1  in_bit is sampled only when high.
- in_bit  input  1  serial data bit.
- cnt_clr  input  1  clears the match counter.
- det  output  1  one-cycle pulse, registered.
- det_count  output  CNT_W  saturating number of matches.
- cfg_err  output  1  high while the active configuration is invalid.

Behaviour:
- Reset (rst=1 at an edge):
  - pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP.
  - History shift register and fill counter = 0.
  - det=0, det_count=0, cfg_err=0.
  - Reset overrides every other input, including mid-stream; partial history is discarded.
- History: MAX_LEN-bit shift register. On each accepted beat (in_valid=1, cfg_load=0): hist <= {hist[MAX_LEN-2:0], in_bit}.
- Fill counter: increments on each accepted beat and saturates at MAX_LEN.
- Match condition, evaluated on an accepted beat using the post-shift view:
  - cfg_err=0, AND
  - fill+1 >= len, AND
  - the low len bits of the new history equal pattern[len-1:0].
- Latency: det is high in the cycle after the edge that accepted the completing bit, i.e. the edge registers det=1. det is 0 on all other cycles. Bubbles (in_valid=0) neither advance nor clear history.
- Overlap=1: history and fill are kept after a match, so "1001001" yields 2 matches.
- Overlap=0: on a match, fill is cleared to 0, so the next match needs len fresh bits.
- cfg_load:
  - The in_valid beat in the same cycle is dropped.
  - History and fill are cleared; det_count is untouched.
  - Load is valid iff 1 <= cfg_len <= MAX_LEN. A valid load sets cfg_err=0 and applies the new configuration.
  - An invalid load sets cfg_err=1, keeps the previous pattern/len, and suppresses matching until the next valid load.
- det_count:
  - Increments at the same edge that registers det=1, saturating at 2^CNT_W-1.
  - cnt_clr alone forces 0.
  - cnt_clr together with a match at the same edge gives 1.
- Pattern bits above len-1 are ignored in the comparison.
- len=1: every accepted bit equal to pattern[0] matches; in non-overlap mode it still matches every such bit.

Test Plan:
- Reset defaults, stream 1,0,0,1,0,0,1 (all valid) -> det pulses after beats 4 and 7; det_count=2.
- Load pattern=1001, len=4, overlap=0; same stream -> det after beat 4 only; det_count=1.
- Load len=3, pattern=101, overlap=1; stream 1,0,1,0,1 with in_valid bubbles between every beat -> det after beats 3 and 5 only, each 1 cycle wide.
- Load len=0 -> cfg_err=1; stream 1,0,0,1 -> no det. Then load len=4, pattern=1001 -> cfg_err=0; 1,0,0,1 -> det.
- Reset mid-stream: beats 1,0,0, then rst pulse, then 1 -> no det; det_count=0.
- CNT_W=2: 5 matches -> det_count stays at 3. cnt_clr asserted on the cycle of a completing beat -> det_count=1.
